// File: rtl/wb_pkg.sv
// Shared widths, FSM state type and counter width for the register writeback controller.
package wb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  // NORMAL lets the pipeline win; FORCE reserves one cycle for the multicycle unit.
  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } state_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard for multicycle destinations, with hazard and issue lookups.
module wb_scoreboard #(
  parameter int REG_AW = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_req,
  input  logic [REG_AW-1:0]    set_idx,
  input  logic                 clr_en,
  input  logic [REG_AW-1:0]    clr_idx,
  input  logic [REG_AW-1:0]    ra1,
  input  logic [REG_AW-1:0]    ra2,
  output logic                 hz1,
  output logic                 hz2,
  output logic                 iss_ok,
  output logic [2**REG_AW-1:0] pending
);

  localparam int NREG = 2**REG_AW;

  logic            set_en;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  // Lookups read the current vector only; a same-cycle issue is not bypassed.
  assign iss_ok = ~pending[set_idx];
  assign hz1    = pending[ra1];
  assign hz2    = pending[ra2];

  // An issue only counts when the dispatcher saw iss_ok; x0 is never tracked.
  assign set_en = set_req & iss_ok & (set_idx != '0);

  // Build one-hot set/clear masks so the update below is a single expression.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_idx] = 1'b1;
    if (clr_en) clr_mask[clr_idx] = 1'b1;
  end

  // Pending vector: clear applied before set, so a colliding set wins; bit 0 stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: this is a flop vector, not a RAM, and decode trusts it immediately after reset, so it is reset.
    if (!rst_n) begin
      pending <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      pending <= ((pending & ~clr_mask) | set_mask) & ~NREG'(1);
    end
  end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Merges pipeline (A) and multicycle (B) writebacks into one registered register-file
// write port, with a starvation FSM guaranteeing B progress and a WAW error flag.
module reg_writeback_ctrl #(
  parameter int XLEN         = wb_pkg::XLEN,
  parameter int REG_AW       = wb_pkg::REG_AW,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [REG_AW-1:0] a_rd,
  input  logic [XLEN-1:0]   a_data,
  output logic              stall_a,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [REG_AW-1:0] b_rd,
  input  logic [XLEN-1:0]   b_data,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_rd,
  output logic              iss_ok,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic              hz1,
  output logic              hz2,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_wa,
  output logic [XLEN-1:0]   rf_wd,
  output logic              err_waw
);

  import wb_pkg::*;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t              state, next_state;
  logic [CNT_W-1:0]    cnt, next_cnt;
  logic                a_grant, b_grant;
  logic [REG_AW-1:0]   wr_rd;
  logic [XLEN-1:0]     wr_data;
  logic                wr_en;
  logic [2**REG_AW-1:0] pending;

  wb_scoreboard #(.REG_AW(REG_AW)) u_scoreboard (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_req (iss_valid),
    .set_idx (iss_rd),
    .clr_en  (b_grant),
    .clr_idx (b_rd),
    .ra1     (ra1),
    .ra2     (ra2),
    .hz1     (hz1),
    .hz2     (hz2),
    .iss_ok  (iss_ok),
    .pending (pending)
  );

  // Arbitration, starvation counting and next-state; handshakes are masked while in reset.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    stall_a    = 1'b0;
    b_ready    = 1'b0;
    a_grant    = 1'b0;
    b_grant    = 1'b0;
    unique case (state)
      NORMAL: begin
        b_ready = ~a_valid;
        a_grant = a_valid;
        b_grant = b_valid & ~a_valid;
        if (a_valid && b_valid) begin
          // Saturate at the limit; the losing cycle at the limit still grants A.
          if (cnt == LIMIT) next_state = FORCE;
          else              next_cnt   = cnt + 1'b1;
        end else begin
          next_cnt = '0;
        end
      end
      FORCE: begin
        stall_a    = 1'b1;
        b_ready    = 1'b1;
        b_grant    = b_valid;
        next_state = NORMAL;
        next_cnt   = '0;
      end
      default: next_state = NORMAL;
    endcase
    if (!rst_n) begin
      stall_a = 1'b0;
      b_ready = 1'b0;
      a_grant = 1'b0;
      b_grant = 1'b0;
    end
  end

  // Write mux: the winner's destination and data; x0 writes are consumed but not issued.
  assign wr_rd   = a_grant ? a_rd   : b_rd;
  assign wr_data = a_grant ? a_data : b_data;
  assign wr_en   = (a_grant | b_grant) & (wr_rd != '0);

  // FSM state and starvation counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= NORMAL;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Registered write port; address/data only load on a real write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else begin
      rf_we <= wr_en;
      if (wr_en) begin
        rf_wa <= wr_rd;
        rf_wd <= wr_data;
      end
    end
  end

  // Sticky flag: the pipeline overwrote a register still owed a multicycle result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_waw <= 1'b0;
    end else if (a_grant && (a_rd != '0) && pending[a_rd]) begin
      err_waw <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Directed bench for reg_writeback_ctrl: A/B writes, x0, starvation, scoreboard, WAW, async reset.
module tb_reg_writeback_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid, iss_valid;
  logic [4:0]  a_rd, b_rd, iss_rd, ra1, ra2;
  logic [31:0] a_data, b_data;
  logic        stall_a, b_ready, iss_ok, hz1, hz2, rf_we, err_waw;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_writeback_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_valid  (a_valid),
    .a_rd     (a_rd),
    .a_data   (a_data),
    .stall_a  (stall_a),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_rd     (b_rd),
    .b_data   (b_data),
    .iss_valid(iss_valid),
    .iss_rd   (iss_rd),
    .iss_ok   (iss_ok),
    .ra1      (ra1),
    .ra2      (ra2),
    .hz1      (hz1),
    .hz2      (hz2),
    .rf_we    (rf_we),
    .rf_wa    (rf_wa),
    .rf_wd    (rf_wd),
    .err_waw  (err_waw)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_valid = 1'b0; a_rd = '0; a_data = '0;
    b_valid = 1'b0; b_rd = '0; b_data = '0;
    iss_valid = 1'b0; iss_rd = '0; ra1 = '0; ra2 = '0;
    #3;
    check("rst_rf_we",   32'(rf_we),   32'd0);
    check("rst_rf_wa",   32'(rf_wa),   32'd0);
    check("rst_rf_wd",   rf_wd,        32'd0);
    check("rst_stall_a", 32'(stall_a), 32'd0);
    check("rst_b_ready", 32'(b_ready), 32'd0);
    check("rst_err_waw", 32'(err_waw), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;

    // 1: A-only write.
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEAD_BEEF;
    #1;
    check("a_only_b_ready", 32'(b_ready), 32'd0);
    check("a_only_stall",   32'(stall_a), 32'd0);
    tick();
    a_valid = 1'b0;
    check("a_only_we", 32'(rf_we), 32'd1);
    check("a_only_wa", 32'(rf_wa), 32'd5);
    check("a_only_wd", rf_wd,      32'hDEAD_BEEF);
    tick();
    check("idle_we", 32'(rf_we), 32'd0);

    // 2: x0 writes from A and B are consumed without rf_we; then a normal B write.
    a_valid = 1'b1; a_rd = 5'd0; a_data = 32'h1234;
    tick();
    a_valid = 1'b0;
    check("x0_a_we", 32'(rf_we), 32'd0);
    b_valid = 1'b1; b_rd = 5'd0; b_data = 32'h55;
    #1;
    check("x0_b_ready", 32'(b_ready), 32'd1);
    tick();
    b_valid = 1'b0;
    check("x0_b_we", 32'(rf_we), 32'd0);
    b_valid = 1'b1; b_rd = 5'd3; b_data = 32'h0B0B;
    tick();
    b_valid = 1'b0;
    check("b_we", 32'(rf_we), 32'd1);
    check("b_wa", 32'(rf_wa), 32'd3);
    check("b_wd", rf_wd,      32'h0B0B);

    // 3: starvation -- five A wins, one forced B cycle, then the held A item once.
    b_valid = 1'b1; b_rd = 5'd12; b_data = 32'hCAFE;
    a_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_rd = 5'(i + 1); a_data = 32'h100 + 32'(i);
      #1;
      check("starve_stall_lo", 32'(stall_a), 32'd0);
      check("starve_b_ready",  32'(b_ready), 32'd0);
      tick();
      check("starve_a_wa", 32'(rf_wa), 32'(i + 1));
      check("starve_a_wd", rf_wd,      32'h100 + 32'(i));
    end
    a_rd = 5'd20; a_data = 32'hA20;
    #1;
    check("force_stall",   32'(stall_a), 32'd1);
    check("force_b_ready", 32'(b_ready), 32'd1);
    tick();
    b_valid = 1'b0;
    check("force_we", 32'(rf_we), 32'd1);
    check("force_wa", 32'(rf_wa), 32'd12);
    check("force_wd", rf_wd,      32'hCAFE);
    #1;
    check("resume_stall", 32'(stall_a), 32'd0);
    tick();
    a_valid = 1'b0;
    check("resume_wa", 32'(rf_wa), 32'd20);
    check("resume_wd", rf_wd,      32'hA20);
    tick();
    check("resume_once_we", 32'(rf_we), 32'd0);

    // 4: scoreboard set by issue, cleared by B commit.
    iss_valid = 1'b1; iss_rd = 5'd7;
    #1;
    check("sb_iss_ok_free", 32'(iss_ok), 32'd1);
    tick();
    iss_valid = 1'b0; ra1 = 5'd7; ra2 = 5'd0;
    #1;
    check("sb_hz1_set", 32'(hz1),    32'd1);
    check("sb_hz2_x0",  32'(hz2),    32'd0);
    check("sb_iss_ok",  32'(iss_ok), 32'd0);
    b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h77;
    tick();
    b_valid = 1'b0;
    check("sb_hz1_clr", 32'(hz1),   32'd0);
    check("sb_b_wa",    32'(rf_wa), 32'd7);

    // 5: set and clear of the same index in one cycle -- set wins.
    b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h99;
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    b_valid = 1'b0; iss_valid = 1'b0; ra2 = 5'd9;
    #1;
    check("collide_hz2", 32'(hz2), 32'd1);

    // WAW: A writes a register still pending for B; flag is sticky.
    a_valid = 1'b1; a_rd = 5'd9; a_data = 32'h1;
    tick();
    a_valid = 1'b0;
    check("waw_set", 32'(err_waw), 32'd1);
    b_valid = 1'b1; b_rd = 5'd9;
    tick();
    b_valid = 1'b0;
    check("waw_sticky",  32'(err_waw), 32'd1);
    check("collide_clr", 32'(hz2),     32'd0);

    // 6: async reset while in FORCE.
    iss_valid = 1'b1; iss_rd = 5'd4; ra1 = 5'd4;
    tick();
    iss_valid = 1'b0;
    a_valid = 1'b1; a_rd = 5'd2; a_data = 32'h2;
    b_valid = 1'b1; b_rd = 5'd14; b_data = 32'hE;
    for (int i = 0; i < 5; i++) tick();
    check("pre_rst_stall", 32'(stall_a), 32'd1);
    check("pre_rst_we",    32'(rf_we),   32'd1);
    check("pre_rst_hz1",   32'(hz1),     32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_we",      32'(rf_we),   32'd0);
    check("mid_rst_stall",   32'(stall_a), 32'd0);
    check("mid_rst_b_ready", 32'(b_ready), 32'd0);
    check("mid_rst_hz1",     32'(hz1),     32'd0);
    check("mid_rst_err",     32'(err_waw), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
